// File: rtl/soc_halt_monitor.sv
// soc_halt_monitor: watches each core's fetch stream and a7 for the exit ecall, records per-core
// cycle counts from run start to termination, and flags when every enabled core has halted.
// Optional feature macro: HALT_TIMEOUT_EN adds a run watchdog that forces DONE after TIMEOUT
// cycles in RUN and raises timeout; without it timeout is tied low.
module soc_halt_monitor #(
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned CNT_W      = 64,
    parameter logic [31:0] ECALL_WORD = 32'h0000_0073,
    parameter logic [31:0] EXIT_CODE  = 32'd1,
    parameter int unsigned TIMEOUT    = 1_000_000,
    localparam int unsigned SEL_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [NUM_CH-1:0]      ch_en,
    input  logic [32*NUM_CH-1:0]   instr,
    input  logic [NUM_CH-1:0]      instr_valid,
    input  logic [32*NUM_CH-1:0]   a7,
    output logic [NUM_CH-1:0]      halted,
    output logic                   all_done,
    output logic                   done_pulse,
    input  logic [SEL_W-1:0]       rd_sel,
    output logic [CNT_W-1:0]       rd_cycles,
    output logic                   timeout
);

    typedef enum logic [1:0] {GIdle, GRun, GDone} state_e;

    state_e              state_q, state_d;
    // start is captured one edge before the run begins, so RUN starts one cycle after start
    logic                start_q, start_d;
    logic [NUM_CH-1:0]   pend_en_q, pend_en_d;
    logic [NUM_CH-1:0]   en_q, en_d;
    logic [NUM_CH-1:0]   halted_q, halted_d;
    logic [NUM_CH-1:0]   detect;
    logic [CNT_W-1:0]    cnt_q [NUM_CH];
    logic [CNT_W-1:0]    cnt_d [NUM_CH];
    logic [CNT_W-1:0]    rd_q, rd_d;
    logic                pulse_q, pulse_d;
`ifdef HALT_TIMEOUT_EN
    logic [CNT_W-1:0]    wd_q, wd_d;
    logic                timeout_q, timeout_d;
`endif

    // Per-channel exit ecall detection, before run/enable/halted qualification
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            detect[i] = instr_valid[i] && (instr[32*i +: 32] == ECALL_WORD) &&
                        (a7[32*i +: 32] == EXIT_CODE);
        end
    end

    // Next-state logic for the run FSM, counters, halted flags and readout register
    always_comb begin
        state_d   = state_q;
        start_d   = start && (|ch_en) && (state_q != GRun);
        pend_en_d = ch_en;
        en_d      = en_q;
        halted_d  = halted_q;
        cnt_d     = cnt_q;
        pulse_d   = 1'b0;
`ifdef HALT_TIMEOUT_EN
        wd_d      = wd_q;
        timeout_d = timeout_q;
`endif
        if (32'(rd_sel) < NUM_CH) begin
            rd_d = cnt_q[rd_sel];
        end else begin
            rd_d = '0;
        end

        unique case (state_q)
            GIdle, GDone: begin
                if (start_q) begin
                    state_d  = GRun;
                    en_d     = pend_en_q;
                    halted_d = '0;
                    for (int i = 0; i < NUM_CH; i++) begin
                        cnt_d[i] = '0;
                    end
`ifdef HALT_TIMEOUT_EN
                    wd_d      = '0;
                    timeout_d = 1'b0;
`endif
                end
            end
            GRun: begin
                // Completion is judged on the flags as they stood before this edge
                if ((halted_q & en_q) == en_q) begin
                    state_d = GDone;
                    pulse_d = 1'b1;
                end
                for (int i = 0; i < NUM_CH; i++) begin
                    if (en_q[i] && !halted_q[i]) begin
                        if (cnt_q[i] != '1) begin
                            cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        end
                        if (detect[i]) begin
                            halted_d[i] = 1'b1;
                        end
                    end
                end
`ifdef HALT_TIMEOUT_EN
                wd_d = wd_q + CNT_W'(1);
                if (wd_d == CNT_W'(TIMEOUT)) begin
                    state_d   = GDone;
                    pulse_d   = 1'b1;
                    timeout_d = 1'b1;
                end
`endif
            end
            default: state_d = GIdle;
        endcase
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= GIdle;
            start_q   <= 1'b0;
            pend_en_q <= '0;
            en_q      <= '0;
            halted_q  <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
            end
            rd_q      <= '0;
            pulse_q   <= 1'b0;
`ifdef HALT_TIMEOUT_EN
            wd_q      <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            start_q   <= start_d;
            pend_en_q <= pend_en_d;
            en_q      <= en_d;
            halted_q  <= halted_d;
            cnt_q     <= cnt_d;
            rd_q      <= rd_d;
            pulse_q   <= pulse_d;
`ifdef HALT_TIMEOUT_EN
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign halted     = halted_q;
    assign all_done   = (state_q == GDone);
    assign done_pulse = pulse_q;
    assign rd_cycles  = rd_q;
`ifdef HALT_TIMEOUT_EN
    assign timeout    = timeout_q;
`else
    assign timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_soc_halt_monitor.sv
// Bench for soc_halt_monitor (NUM_CH=2, TIMEOUT=100): a run-level model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_soc_halt_monitor;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [1:0]  ch_en, instr_valid, halted;
    logic [63:0] instr, a7;
    logic        all_done, done_pulse, timeout;
    logic [0:0]  rd_sel;
    logic [63:0] rd_cycles;

    soc_halt_monitor #(.NUM_CH(2), .CNT_W(64), .TIMEOUT(100)) dut (
        .clk(clk), .reset(reset), .start(start), .ch_en(ch_en), .instr(instr),
        .instr_valid(instr_valid), .a7(a7), .halted(halted), .all_done(all_done),
        .done_pulse(done_pulse), .rd_sel(rd_sel), .rd_cycles(rd_cycles), .timeout(timeout)
    );

    always #5 clk = ~clk;

`ifdef HALT_TIMEOUT_EN
    localparam bit TO_ON = 1'b1;
`else
    localparam bit TO_ON = 1'b0;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;
    int pulse_seen = 0;
    int pos = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Run-level model: mode 0 idle, 1 run, 2 done; m_el counts RUN edges elapsed
    int              m_mode = 0;
    bit              m_pend = 0;
    bit [1:0]        m_pend_en = 0, m_en = 0, m_h = 0, det;
    longint unsigned m_el = 0;
    longint unsigned m_at [2] = '{0, 0};
    bit              m_pulse = 0, m_to = 0, was_run, all_h;
    logic [63:0]     m_rd = 0;

    function automatic longint unsigned m_count(input int i);
        if (!m_en[i]) return 0;
        return m_h[i] ? m_at[i] : m_el;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++)
            det[i] = instr_valid[i] && instr[32*i +: 32] == 32'h73 && a7[32*i +: 32] == 32'd1;
        was_run = (m_mode == 1);
        if (reset) begin
            m_mode = 0; m_pend = 0; m_pend_en = 0; m_en = 0; m_h = 0; m_el = 0;
            m_at[0] = 0; m_at[1] = 0; m_pulse = 0; m_to = 0; m_rd = 0;
        end else begin
            m_rd = m_count(int'(rd_sel));
            m_pulse = 0;
            if (m_mode == 1) begin
                all_h = ((m_h & m_en) == m_en);
                m_el++;
                for (int i = 0; i < 2; i++)
                    if (m_en[i] && !m_h[i] && det[i]) begin
                        m_h[i] = 1; m_at[i] = m_el;
                    end
                if (TO_ON && m_el == 100) begin
                    m_mode = 2; m_pulse = 1; m_to = 1;
                end else if (all_h) begin
                    m_mode = 2; m_pulse = 1;
                end
            end else if (m_pend) begin
                m_mode = 1; m_en = m_pend_en; m_h = 0; m_el = 0; m_to = 0;
            end
            m_pend = start && (ch_en != 0) && !was_run;
            m_pend_en = ch_en;
        end
        #1;
        chk("halted", halted, m_h);
        chk("all_done", all_done, m_mode == 2);
        chk("done_pulse", done_pulse, m_pulse);
        chk("timeout", timeout, m_to);
        chk("rd_cycles", rd_cycles, m_rd);
        if (done_pulse === 1'b1) pulse_seen++;
    end

    task automatic do_start(input logic [1:0] en);
        start = 1'b1; ch_en = en;
        @(negedge clk);
        start = 1'b0; pos = 0;
    endtask

    task automatic goto(input int m);
        while (pos < m) begin
            @(negedge clk);
            pos++;
        end
    endtask

    task automatic exit_ch(input logic [1:0] mask, input logic [31:0] a7v, input logic v);
        for (int i = 0; i < 2; i++) begin
            instr[32*i +: 32] = mask[i] ? 32'h73 : 32'h13;
            a7[32*i +: 32] = mask[i] ? a7v : 32'd0;
        end
        instr_valid = v ? mask : 2'b00;
        @(negedge clk);
        instr = '0; a7 = '0; instr_valid = '0; pos++;
    endtask

    task automatic rd_chk(input string name, input logic s, input logic [63:0] exp);
        rd_sel = s;
        @(negedge clk);
        chk(name, rd_cycles, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        reset = 1'b1; start = 1'b0; ch_en = '0; instr = '0; a7 = '0; instr_valid = '0;
        rd_sel = '0;
        repeat (2) @(negedge clk);
        chk("rst_halted", halted, 2'b00);
        chk("rst_all_done", all_done, 1'b0);
        chk("rst_rd", rd_cycles, 64'd0);
        chk("rst_timeout", timeout, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        // Two channels exit at cycles 10 and 25
        pulse_seen = 0;
        do_start(2'b11);
        goto(10); exit_ch(2'b01, 32'd1, 1'b1);
        chk("t1_halted01", halted, 2'b01);
        goto(25); exit_ch(2'b10, 32'd1, 1'b1);
        chk("t1_halted11", halted, 2'b11);
        chk("t1_not_done_yet", all_done, 1'b0);
        @(negedge clk);
        chk("t1_done", all_done, 1'b1);
        chk("t1_pulse", done_pulse, 1'b1);
        @(negedge clk);
        chk("t1_pulse_gone", done_pulse, 1'b0);
        rd_chk("t1_rd1", 1'b1, 64'd25);
        rd_chk("t1_rd0", 1'b0, 64'd10);
        chk("t1_one_pulse", pulse_seen, 1);

        // Wrong a7 and invalid fetch must not halt
        do_start(2'b01);
        goto(3); exit_ch(2'b01, 32'd0, 1'b1);
        goto(4); exit_ch(2'b01, 32'd1, 1'b0);
        chk("t2_no_halt", halted, 2'b00);
        goto(6); exit_ch(2'b01, 32'd1, 1'b1);
        chk("t2_halt", halted, 2'b01);
        @(negedge clk);
        rd_chk("t2_rd0", 1'b0, 64'd6);
        rd_chk("t2_rd1", 1'b1, 64'd0);

        // Disabled channel exit is ignored
        do_start(2'b01);
        goto(2); exit_ch(2'b10, 32'd1, 1'b1);
        chk("t3_ignored", halted, 2'b00);
        goto(7); exit_ch(2'b01, 32'd1, 1'b1);
        chk("t3_halted", halted, 2'b01);
        @(negedge clk);
        chk("t3_done", all_done, 1'b1);
        rd_chk("t3_rd1", 1'b1, 64'd0);
        rd_chk("t3_rd0", 1'b0, 64'd7);

        // Simultaneous exits
        pulse_seen = 0;
        do_start(2'b11);
        goto(5); exit_ch(2'b11, 32'd1, 1'b1);
        chk("t4_halted", halted, 2'b11);
        repeat (3) @(negedge clk);
        rd_chk("t4_rd0", 1'b0, 64'd5);
        rd_chk("t4_rd1", 1'b1, 64'd5);
        chk("t4_one_pulse", pulse_seen, 1);

        // Reset mid-run, new run, ignored restart
        pulse_seen = 0;
        do_start(2'b11);
        goto(3);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("t5_rst_halted", halted, 2'b00);
        chk("t5_rst_done", all_done, 1'b0);
        chk("t5_rst_rd", rd_cycles, 64'd0);
        repeat (3) @(negedge clk);
        chk("t5_no_pulse", pulse_seen, 0);
        do_start(2'b11);
        goto(1); exit_ch(2'b01, 32'd1, 1'b1);
        goto(4);
        start = 1'b1; ch_en = 2'b01;
        @(negedge clk);
        start = 1'b0; pos++;
        goto(9); exit_ch(2'b10, 32'd1, 1'b1);
        @(negedge clk);
        rd_chk("t5_rd0", 1'b0, 64'd1);
        rd_chk("t5_rd1", 1'b1, 64'd9);
        chk("t5_one_pulse", pulse_seen, 1);
        chk("t5_done", all_done, 1'b1);

`ifdef HALT_TIMEOUT_EN
        // Watchdog ends a run where ch1 never exits
        pulse_seen = 0;
        do_start(2'b11);
        goto(20); exit_ch(2'b01, 32'd1, 1'b1);
        for (int n = 0; n < 200 && all_done !== 1'b1; n++) @(negedge clk);
        chk("t6_done_seen", all_done, 1'b1);
        chk("t6_timeout", timeout, 1'b1);
        chk("t6_halted", halted, 2'b01);
        rd_chk("t6_rd1", 1'b1, 64'd100);
        rd_chk("t6_rd0", 1'b0, 64'd20);
        chk("t6_one_pulse", pulse_seen, 1);
`else
        // Without the watchdog an unfinished run never completes
        do_start(2'b11);
        goto(5); exit_ch(2'b01, 32'd1, 1'b1);
        repeat (150) @(negedge clk);
        chk("t6_still_running", all_done, 1'b0);
        chk("t6_no_timeout", timeout, 1'b0);
        chk("t6_halted", halted, 2'b01);
        rd_chk("t6_rd0", 1'b0, 64'd5);
`endif
        reset = 1'b1;
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/soc_halt_monitor.md
# soc_halt_monitor

Synthesizable multi-channel program-termination monitor for the SoC. It watches the instruction fetch stream and syscall register (a7) of up to NUM_CH RISC-V cores (main CPU plus PIM cores) for the exit ecall. Per core it records the cycle count from run start to termination and latches a halted flag. It aggregates an all-done indication, so benches and on-chip logic no longer need ad-hoc hierarchical probes to detect program completion.

## Interface
- NUM_CH, 2: number of monitored cores (1..16).
- CNT_W, 64: cycle counter width.
- ECALL_WORD, 32'h00000073: instruction word treated as ecall.
- EXIT_CODE, 32'd1: a7 value that marks program exit.
- TIMEOUT, 1_000_000: watchdog limit in cycles (used only with HALT_TIMEOUT_EN).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; begins a run.
- ch_en  in  NUM_CH  channels taking part in the run; sampled with start.
- instr  in  32*NUM_CH  fetched instruction word; channel i at [32*i +: 32].
- instr_valid  in  NUM_CH  instr[i] is a valid fetch this cycle.
- a7  in  32*NUM_CH  current x17 value per channel.
- halted  out  NUM_CH  channel i has executed the exit ecall in this run.
- all_done  out  1  level; run finished.
- done_pulse  out  1  one-cycle pulse on entry to DONE.
- rd_sel  in  $clog2(NUM_CH) (min 1)  channel selected for readout.
- rd_cycles  out  CNT_W  registered cycle count of the selected channel.
- timeout  out  1  run ended by watchdog (tied 0 without HALT_TIMEOUT_EN).

## Operation
- Global FSM states are G_IDLE, G_RUN and G_DONE.
- G_IDLE/G_DONE -> G_RUN: on start with ch_en != 0.
  - Latch ch_en into en_q.
  - Clear all counters, halted, timeout and all_done.
- start with ch_en == 0 is ignored. start while in G_RUN is ignored.
- Per-channel detect: instr_valid[i] && instr[i] == ECALL_WORD && a7[i] == EXIT_CODE.
- A detect is honoured only in G_RUN, only when en_q[i] = 1, and only when halted[i] = 0.
- Per-channel counter:
  - Increments on every clock edge in G_RUN while halted[i] = 0, including the edge that sets halted[i].
  - Frozen afterwards.
  - Saturates at all-ones, with no wrap.
- Disabled channels keep their counter at 0 and halted at 0.
- G_RUN -> G_DONE: on the edge after (halted & en_q) == en_q.
  - done_pulse is high for exactly the first G_DONE cycle.
  - all_done stays high for the whole G_DONE period.
- Detects for the same channel after halting are ignored. Simultaneous detects on several channels are all recorded on the same edge.
- rd_cycles is a register: it equals counter[rd_sel] as sampled on the previous edge. An rd_sel value >= NUM_CH returns 0.

## Timing
- Reset values: halted = 0, all_done = 0, done_pulse = 0, timeout = 0, rd_cycles = 0, all counters = 0, FSM = G_IDLE.
- Reset asserted mid-run aborts the run on that edge, with no done_pulse.
- Cycle numbering: start sampled at edge k, so G_RUN begins at k+1.
  - A detect presented during the first G_RUN cycle (sampled at edge k+2) gives count 1, and halted[i] = 1 after edge k+2.
  - In general, a detect sampled at edge k+1+m gives count m.
- all_done latency: one edge after the last enabled channel's halted flag sets.
- rd_cycles latency: 1 cycle from a change of rd_sel or of the counter.

## Configuration
- HALT_TIMEOUT_EN defined:
  - A watchdog counter runs in G_RUN.
  - When it reaches TIMEOUT, the FSM enters G_DONE on that edge with timeout = 1 and done_pulse asserted.
  - Unhalted channels keep halted = 0, and their counters freeze at TIMEOUT.
  - timeout is cleared by reset or by the next accepted start.
- HALT_TIMEOUT_EN undefined:
  - No watchdog logic; timeout is tied to 0.
  - A run with a channel that never halts stays in G_RUN indefinitely.

## Test plan
- NUM_CH=2, ch_en=2'b11, start; ecall with a7=1 on ch0 at RUN cycle 10 and on ch1 at RUN cycle 25 -> halted=01 then 11; counts 10 and 25; done_pulse for one cycle one edge after the ch1 halt; rd_sel=1 gives rd_cycles=25 after one cycle.
- ecall on ch0 with a7=0, then instr_valid=0 with ecall/a7=1 -> no halt; ecall with a7=1 and valid -> halt at the correct count.
- ch_en=2'b01; ch1 issues an exit ecall; ch0 exits at cycle 7 -> all_done after ch0 only; halted=01; ch1 count 0.
- Both channels exit on the same cycle 5 -> halted goes to 11 on one edge; both counts 5; a single done_pulse.
- Reset asserted at RUN cycle 3, then a new start -> all outputs 0, no done_pulse; the new run counts from 1. A second start mid-run is ignored and counts continue.
- HALT_TIMEOUT_EN, TIMEOUT=100, ch1 never exits -> at cycle 100: timeout=1, all_done=1, halted[1]=0, ch1 count 100.
